// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Registered Rijndael row-shift stage (ShiftRows / InvShiftRows) for 4-, 6- or
// 8-column states. The byte permutation is combinational on the input side.
// The result is held in a two-entry output buffer: a main entry M that drives
// the outputs, and a skid entry S behind it. With S, o_ready can be a pure
// register output while the stage still sustains one block per cycle under
// backpressure.
//
// Parameters
//   NB     number of 32-bit state columns (4, 6 or 8)
//   TAG_W  width of the sideband tag carried with each block
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_flush  synchronous flush, discards both buffered entries
//   i_valid  input block valid
//   o_ready  stage can accept a block this cycle (registered, = !S.valid)
//   i_inv    0 = ShiftRows, 1 = InvShiftRows, sampled with the block
//   i_tag    sideband tag, passed through unchanged
//   i_block  state; column c = bits [32*(NB-c)-1 -: 32], row r = [31-8r -: 8]
//   o_valid  output block valid (M.valid)
//   i_ready  downstream accepts the output
//   o_block  shifted state, same packing as i_block
//   o_tag    tag of the block on o_block
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_inv,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [32*NB-1:0]  i_block,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [32*NB-1:0]  o_block,
    output logic [TAG_W-1:0]  o_tag
);

    localparam int W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    // Row offset table: the 8-column state uses a wider spread for rows 2 and
    // 3 so that diffusion still covers the whole state in few rounds.
    function automatic int row_off(input int r);
        if (NB == 8) begin
            case (r)
                0:       return 0;
                1:       return 1;
                2:       return 3;
                default: return 4;
            endcase
        end
        return r;
    endfunction

    // Byte permutation. Forward takes each output byte from column c+s_r,
    // inverse from column c-s_r (both modulo NB); row index never changes.
    function automatic logic [W-1:0] shift_state(input logic [W-1:0] blk,
                                                 input logic           inv);
        logic [W-1:0] res;
        int           src;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) begin
                    src = (c - row_off(r) + NB) % NB;
                end else begin
                    src = (c + row_off(r)) % NB;
                end
                res[32*(NB-c)-1-8*r -: 8] = blk[32*(NB-src)-1-8*r -: 8];
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Input side: combinational shift of the offered block
    // -------------------------------------------------------------------------
    logic [W-1:0] shf_blk;
    logic         acc;
    logic         pop;

    assign shf_blk = shift_state(i_block, i_inv);

    // Buffer state
    logic             m_vld_q, m_vld_d;
    logic             s_vld_q, s_vld_d;
    logic [W-1:0]     m_blk_q, m_blk_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d;
    logic [W-1:0]     s_blk_q, s_blk_d;
    logic [TAG_W-1:0] s_tag_q, s_tag_d;

    assign o_ready = !s_vld_q;
    assign o_valid = m_vld_q;
    assign o_block = m_blk_q;
    assign o_tag   = m_tag_q;

    assign acc = i_valid && o_ready;
    assign pop = o_valid && i_ready;

    // Next-state for the two entries. S can only be valid while o_ready=0, so
    // the S->M move never coincides with an accept.
    always_comb begin
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        m_blk_d = m_blk_q;
        m_tag_d = m_tag_q;
        s_blk_d = s_blk_q;
        s_tag_d = s_tag_q;

        if (i_flush) begin
            // Data registers keep stale contents; only the valids matter.
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (s_vld_q && pop) begin
            m_blk_d = s_blk_q;
            m_tag_d = s_tag_q;
            s_vld_d = 1'b0;
        end else if (acc && (!m_vld_q || pop)) begin
            m_vld_d = 1'b1;
            m_blk_d = shf_blk;
            m_tag_d = i_tag;
        end else if (acc && m_vld_q && !pop) begin
            s_vld_d = 1'b1;
            s_blk_d = shf_blk;
            s_tag_d = i_tag;
        end else if (pop) begin
            m_vld_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output side: main entry (drives the outputs, reset to zero)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            m_blk_q <= '0;
            m_tag_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            m_blk_q <= m_blk_d;
            m_tag_q <= m_tag_d;
        end
    end

    // Skid entry payload is never observed while s_vld_q=0, so it needs no reset.
    always_ff @(posedge i_clk) begin
        s_blk_q <= s_blk_d;
        s_tag_q <= s_tag_d;
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // NB=4 instance
    logic         flush4, vld4, inv4, rdy4, ordy4, ovld4;
    logic [3:0]   tag4, otag4;
    logic [127:0] blk4, oblk4;

    // NB=8 instance
    logic         flush8, vld8, inv8, rdy8, ordy8, ovld8;
    logic [3:0]   tag8, otag8;
    logic [255:0] blk8, oblk8;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush4), .i_valid(vld4),
        .o_ready(ordy4), .i_inv(inv4), .i_tag(tag4), .i_block(blk4),
        .o_valid(ovld4), .i_ready(rdy4), .o_block(oblk4), .o_tag(otag4)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush8), .i_valid(vld8),
        .o_ready(ordy8), .i_inv(inv8), .i_tag(tag8), .i_block(blk8),
        .o_valid(ovld8), .i_ready(rdy8), .o_block(oblk8), .o_tag(otag8)
    );

    typedef struct {
        logic [127:0] blk;
        logic         inv;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[6];

    int n_chk  = 0;
    int n_pass = 0;
    logic acc_last;
    logic [127:0] pop_blk[$];
    logic [3:0]   pop_tag[$];
    int idx;
    int t;

    localparam logic [255:0] IN8  = 256'h00102030_01112131_02122232_03132333_04142434_05152535_06162636_07172737;
    localparam logic [255:0] EXP8 = 256'h00112334_01122435_02132536_03142637_04152730_05162031_06172132_07102233;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: record the pop and accept that the coming edge performs,
    // then advance to 1ns past the edge.
    task automatic tick();
        if (ovld4 && rdy4 && !rst) begin
            pop_blk.push_back(oblk4);
            pop_tag.push_back(otag4);
        end
        acc_last = vld4 && ordy4 && !flush4 && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input int i, input logic [3:0] tg);
        vld4 = 1'b1;
        blk4 = vecs[i].blk;
        inv4 = vecs[i].inv;
        tag4 = tg;
    endtask

    // Backpressure producer: advance through vecs[0..3] with tags 1..4.
    task automatic adv_bp();
        if (acc_last) idx++;
        if (idx < 4) drive4(idx, 4'(idx + 1));
        else vld4 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 1'b0, 4'h5,
                    128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        vecs[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 4'ha,
                    128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
        vecs[2] = '{128'h00102030_01112131_02122232_03132333, 1'b0, 4'h3,
                    128'h00112233_01122330_02132031_03102132};
        vecs[3] = '{128'h00102030_01112131_02122232_03132333, 1'b1, 4'hc,
                    128'h00132231_01102332_02112033_03122130};
        vecs[4] = '{128'h11223344_11223344_11223344_11223344, 1'b0, 4'h0,
                    128'h11223344_11223344_11223344_11223344};
        vecs[5] = '{128'h00112233_01122330_02132031_03102132, 1'b1, 4'hf,
                    128'h00102030_01112131_02122232_03132333};

        rst = 1'b1;
        flush4 = 0; vld4 = 0; inv4 = 0; rdy4 = 1; tag4 = 0; blk4 = '0;
        flush8 = 0; vld8 = 0; inv8 = 0; rdy8 = 1; tag8 = 0; blk8 = '0;
        acc_last = 0; idx = 0; t = 0;

        @(posedge clk); @(posedge clk); #1;
        chk("rst_ovalid", 256'(ovld4), 256'(0));
        chk("rst_oready", 256'(ordy4), 256'(1));
        chk("rst_oblock", 256'(oblk4), 256'(0));
        chk("rst_otag",   256'(otag4), 256'(0));
        rst = 1'b0;

        // Table vectors, back to back (one block per cycle).
        for (int i = 0; i < 6; i++) begin
            drive4(i, vecs[i].tag);
            tick();
            chk($sformatf("vec%0d_valid", i), 256'(ovld4), 256'(1));
            chk($sformatf("vec%0d_block", i), 256'(oblk4), 256'(vecs[i].exp));
            chk($sformatf("vec%0d_tag", i),   256'(otag4), 256'(vecs[i].tag));
            chk($sformatf("vec%0d_ready", i), 256'(ordy4), 256'(1));
        end
        vld4 = 0;
        tick();
        chk("drain_valid", 256'(ovld4), 256'(0));

        // NB=8 forward then inverse.
        vld8 = 1; blk8 = IN8; inv8 = 0; tag8 = 4'h7;
        tick();
        chk("nb8_fwd_valid", 256'(ovld8), 256'(1));
        chk("nb8_fwd_col0", 256'(oblk8[255:224]), 256'(32'h00112334));
        chk("nb8_fwd_col7", 256'(oblk8[31:0]), 256'(32'h07102233));
        chk("nb8_fwd_block", oblk8, EXP8);
        chk("nb8_fwd_tag", 256'(otag8), 256'(4'h7));
        blk8 = EXP8; inv8 = 1; tag8 = 4'h9;
        tick();
        chk("nb8_inv_block", oblk8, IN8);
        chk("nb8_inv_tag", 256'(otag8), 256'(4'h9));
        vld8 = 0;
        tick();

        // Backpressure: 4 blocks offered while downstream stalls.
        pop_blk.delete(); pop_tag.delete();
        rdy4 = 0; idx = 0;
        drive4(0, 4'd1);
        tick(); adv_bp();
        tick(); adv_bp();
        chk("bp_oready_low", 256'(ordy4), 256'(0));
        chk("bp_accepted", 256'(idx), 256'(2));
        chk("bp_head_block", 256'(oblk4), 256'(vecs[0].exp));
        tick(); adv_bp();
        tick(); adv_bp();
        chk("bp_hold_block", 256'(oblk4), 256'(vecs[0].exp));
        chk("bp_hold_tag", 256'(otag4), 256'(1));
        chk("bp_hold_valid", 256'(ovld4), 256'(1));
        chk("bp_no_extra_acc", 256'(idx), 256'(2));
        rdy4 = 1;
        tick(); adv_bp();
        t = 1;
        chk("bp_oready_rise", 256'(ordy4), 256'(1));
        while (pop_blk.size() < 4 && t < 10) begin
            tick(); adv_bp();
            t++;
        end
        chk("bp_pop_cycles", 256'(t), 256'(4));
        chk("bp_pop_count", 256'(pop_blk.size()), 256'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < pop_blk.size()) begin
                chk($sformatf("bp_out%0d_block", i), 256'(pop_blk[i]), 256'(vecs[i].exp));
                chk($sformatf("bp_out%0d_tag", i),   256'(pop_tag[i]), 256'(i + 1));
            end
        end
        vld4 = 0;
        tick();
        chk("bp_empty_after", 256'(ovld4), 256'(0));

        // Flush with both entries full.
        rdy4 = 0; idx = 0;
        drive4(2, 4'h6);
        tick();
        drive4(3, 4'h7);
        tick();
        vld4 = 0;
        chk("fl_full_oready", 256'(ordy4), 256'(0));
        flush4 = 1;
        tick();
        flush4 = 0;
        chk("fl_ovalid", 256'(ovld4), 256'(0));
        chk("fl_oready", 256'(ordy4), 256'(1));
        rdy4 = 1;
        drive4(1, 4'h8);
        tick();
        vld4 = 0;
        chk("fl_next_valid", 256'(ovld4), 256'(1));
        chk("fl_next_block", 256'(oblk4), 256'(vecs[1].exp));
        chk("fl_next_tag", 256'(otag4), 256'(4'h8));
        tick();
        chk("fl_next_alone", 256'(ovld4), 256'(0));
        // Flush coinciding with an accept drops the block.
        drive4(0, 4'h2);
        flush4 = 1;
        tick();
        flush4 = 0; vld4 = 0;
        chk("fl_acc_dropped", 256'(ovld4), 256'(0));
        tick();
        chk("fl_acc_still_empty", 256'(ovld4), 256'(0));

        // Async reset between clock edges while holding two blocks.
        rdy4 = 0;
        drive4(2, 4'h4);
        tick();
        drive4(3, 4'h5);
        tick();
        vld4 = 0;
        chk("ar_pre_valid", 256'(ovld4), 256'(1));
        #3;
        rst = 1'b1;
        #1;
        chk("ar_ovalid", 256'(ovld4), 256'(0));
        chk("ar_oblock", 256'(oblk4), 256'(0));
        chk("ar_otag", 256'(otag4), 256'(0));
        chk("ar_oready", 256'(ordy4), 256'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy4 = 1;
        drive4(0, 4'hb);
        tick();
        vld4 = 0;
        chk("ar_resume_valid", 256'(ovld4), 256'(1));
        chk("ar_resume_block", 256'(oblk4), 256'(vecs[0].exp));
        chk("ar_resume_tag", 256'(otag4), 256'(4'hb));
        tick();
        chk("ar_resume_drain", 256'(ovld4), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
